// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
//   Shared types and helpers for the instruction fetch unit and its consumers.
//   - fetch_state_t : fetch FSM states (FETCH, COLLECT, HOLD)
//   - instr_len_t   : instruction byte-count encoding and its constants
//   - instr_len_of  : length decode from the top two bits of byte0
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    localparam int LEN_W = 2;
    typedef logic [LEN_W-1:0] instr_len_t;

    localparam instr_len_t LEN_NONE = 2'd0;
    localparam instr_len_t LEN_1    = 2'd1;
    localparam instr_len_t LEN_2    = 2'd2;
    localparam instr_len_t LEN_3    = 2'd3;

    // hdr is byte0[WIDTH-1:WIDTH-2]
    function automatic instr_len_t instr_len_of(input logic [1:0] hdr);
        case (hdr)
            2'b10:   return LEN_2;
            2'b11:   return LEN_3;
            default: return LEN_1;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the ROM, decode and redirect signals of the fetch unit.
//   master : fetch unit side (drives rom_addr and the instr_* outputs)
//   slave  : environment side (ROM data, decode ready, branch redirect)
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0]      rom_q;
    logic [3*WIDTH-1:0]    instr;
    instr_len_t            instr_len;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  br_en;
    logic [ADDR_WIDTH-1:0] br_addr;

    modport master (
        output rom_addr, instr, instr_len, instr_pc, instr_valid,
        input  rom_q, instr_ready, br_en, br_addr
    );

    modport slave (
        input  rom_addr, instr, instr_len, instr_pc, instr_valid,
        output rom_q, instr_ready, br_en, br_addr
    );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Byte-serial fetch unit in front of a combinational instruction ROM.
//   Drives rom_addr from the fetch PC, assembles 1..3 byte instructions and
//   offers them to decode on a valid/ready handshake; accepts branch redirects.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - instr_fetch_if.master (rom_addr/rom_q, instr/instr_len/instr_pc,
//            instr_valid/instr_ready, br_en/br_addr)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int RESET_PC   = 0
)(
    input  logic             clk,
    input  logic             rst,
    instr_fetch_if.master    bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_X    = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT   = ADDR_WIDTH'(RESET_PC);

    fetch_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [3*WIDTH-1:0]    instr_q;
    instr_len_t            len_q;
    logic [ADDR_WIDTH-1:0] ipc_q;
    logic [1:0]            rem_q;    // bytes still to collect
    logic [1:0]            slot_q;   // instr slot for the next collected byte

    logic                  load_b0;
    instr_len_t            b0_len;
    logic [ADDR_WIDTH-1:0] br_target;

    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // br_addr is below 2*SIZE, so one conditional subtract is a full modulo.
    assign br_target = ({1'b0, bus.br_addr} >= SIZE_X)
                     ? bus.br_addr - SIZE_X[ADDR_WIDTH-1:0]
                     : bus.br_addr;

    assign b0_len = instr_len_of(bus.rom_q[WIDTH-1 -: 2]);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        load_b0   = 1'b0;
        if (bus.br_en) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    load_b0   = 1'b1;
                    state_nxt = (b0_len == LEN_1) ? HOLD : COLLECT;
                end
                COLLECT: begin
                    state_nxt = (rem_q == 2'd1) ? HOLD : COLLECT;
                end
                HOLD: begin
                    // Accepting the held instruction doubles as the next byte0 fetch.
                    if (bus.instr_ready) begin
                        load_b0   = 1'b1;
                        state_nxt = (b0_len == LEN_1) ? HOLD : COLLECT;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // State, PC and instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            instr_q <= '0;
            len_q   <= LEN_NONE;
            ipc_q   <= '0;
            rem_q   <= '0;
            slot_q  <= '0;
        end else begin
            state <= state_nxt;
            if (bus.br_en) begin
                pc     <= br_target;
                rem_q  <= '0;
                slot_q <= '0;
            end else if (load_b0) begin
                instr_q <= {{(2*WIDTH){1'b0}}, bus.rom_q};
                len_q   <= b0_len;
                ipc_q   <= pc;
                rem_q   <= b0_len - 2'd1;
                slot_q  <= 2'd1;
                pc      <= pc_inc(pc);
            end else if (state == COLLECT) begin
                case (slot_q)
                    2'd1:    instr_q[2*WIDTH-1:WIDTH]   <= bus.rom_q;
                    default: instr_q[3*WIDTH-1:2*WIDTH] <= bus.rom_q;
                endcase
                slot_q <= slot_q + 2'd1;
                rem_q  <= rem_q - 2'd1;
                pc     <= pc_inc(pc);
            end
        end
    end

    // Outputs (all derived from registers only)
    always_comb begin
        bus.rom_addr    = pc;
        bus.instr       = instr_q;
        bus.instr_len   = len_q;
        bus.instr_pc    = ipc_q;
        bus.instr_valid = (state == HOLD);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Self-checking bench for instr_fetch with a behavioural combinational ROM.
//   Expected instructions are queued when a test sets up an acceptance; a
//   monitor pops and compares on every handshake.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    typedef struct packed {
        logic [23:0] instr;
        logic [1:0]  len;
        logic [9:0]  pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rom [0:1023];
    exp_t       sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    instr_fetch_if #(.WIDTH(8), .ADDR_WIDTH(10)) bus ();

    instr_fetch #(
        .WIDTH(8), .SIZE(1024), .ADDR_WIDTH(10), .RESET_PC(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_q = rom[bus.rom_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] i, input logic [1:0] l, input logic [9:0] p);
        exp_t e;
        e.instr = i;
        e.len   = l;
        e.pc    = p;
        sb.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'h0);
        check({tag, "_instr"},    32'(bus.instr), 32'h0);
        check({tag, "_len"},      32'(bus.instr_len), 32'h0);
        check({tag, "_pc"},       32'(bus.instr_pc), 32'h0);
        check({tag, "_valid"},    32'(bus.instr_valid), 32'h0);
    endtask

    // Leaves rst asserted; caller releases it.
    task automatic do_reset(input string tag);
        rst             = 1'b1;
        bus.br_en       = 1'b0;
        bus.br_addr     = '0;
        bus.instr_ready = 1'b0;
        step();
        step();
        check_reset_vals(tag);
    endtask

    task automatic accept_one();
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        check({tag, "_sb_drain"}, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.br_en       = 1'b0;
        bus.br_addr     = '0;
        clear_rom();

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.instr_valid && bus.instr_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_instr", 32'(bus.instr_pc), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_instr", 32'(bus.instr), 32'(e.instr));
                        check("sb_len",   32'(bus.instr_len), 32'(e.len));
                        check("sb_pc",    32'(bus.instr_pc), 32'(e.pc));
                    end
                end
            end
        join_none

        // Reset then six 1-byte instructions back to back
        clear_rom();
        rom[0] = 8'h05; rom[1] = 8'h06; rom[2] = 8'h07;
        rom[3] = 8'h08; rom[4] = 8'h09; rom[5] = 8'h0A;
        do_reset("rst0");
        for (int i = 0; i < 6; i++) push(24'(8'h05 + i), 2'd1, 10'(i));
        bus.instr_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("seq_valid", 32'(bus.instr_valid), 32'h1);
        end
        step();
        bus.instr_ready = 1'b0;
        drain("seq");

        // 3-byte instruction held under back-pressure
        clear_rom();
        rom[0] = 8'hC1; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h05;
        do_reset("rst1");
        rst = 1'b0;
        step();
        check("len3_lat1_valid", 32'(bus.instr_valid), 32'h0);
        step();
        check("len3_lat2_valid", 32'(bus.instr_valid), 32'h0);
        step();
        check("len3_lat3_valid", 32'(bus.instr_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_valid",    32'(bus.instr_valid), 32'h1);
            check("hold_instr",    32'(bus.instr), 32'h3322C1);
            check("hold_len",      32'(bus.instr_len), 32'h3);
            check("hold_pc",       32'(bus.instr_pc), 32'h0);
            check("hold_rom_addr", 32'(bus.rom_addr), 32'h3);
        end
        push(24'h3322C1, 2'd3, 10'd0);
        accept_one();
        check("after_hold_instr", 32'(bus.instr), 32'h05);
        check("after_hold_pc",    32'(bus.instr_pc), 32'h3);
        check("after_hold_valid", 32'(bus.instr_valid), 32'h1);
        drain("hold");

        // Branch during COLLECT
        clear_rom();
        rom[0] = 8'h81; rom[1] = 8'h55; rom[10'h100] = 8'h04;
        do_reset("rst2");
        rst = 1'b0;
        step();
        bus.br_en   = 1'b1;
        bus.br_addr = 10'h100;
        step();
        bus.br_en = 1'b0;
        check("br_valid_low", 32'(bus.instr_valid), 32'h0);
        check("br_rom_addr",  32'(bus.rom_addr), 32'h100);
        step();
        check("br_valid", 32'(bus.instr_valid), 32'h1);
        push(24'h000004, 2'd1, 10'h100);
        accept_one();
        drain("br");

        // Wrap across the top of the ROM; rst also overrides a pending branch
        clear_rom();
        rom[1023] = 8'h80; rom[0] = 8'hAB; rom[1] = 8'h05;
        do_reset("rst3");
        bus.br_en   = 1'b1;
        bus.br_addr = 10'd1023;
        step();
        check("rst_over_br_addr",  32'(bus.rom_addr), 32'h0);
        check("rst_over_br_valid", 32'(bus.instr_valid), 32'h0);
        rst = 1'b0;
        step();
        bus.br_en = 1'b0;
        check("wrap_br_addr", 32'(bus.rom_addr), 32'd1023);
        step();
        check("wrap_rom_addr0", 32'(bus.rom_addr), 32'h0);
        step();
        check("wrap_valid",     32'(bus.instr_valid), 32'h1);
        check("wrap_rom_addr1", 32'(bus.rom_addr), 32'h1);
        push(24'h00AB80, 2'd2, 10'd1023);
        accept_one();
        check("wrap_next_pc",    32'(bus.instr_pc), 32'h1);
        check("wrap_next_instr", 32'(bus.instr), 32'h05);
        drain("wrap");

        // Branch coinciding with a handshake
        clear_rom();
        rom[0] = 8'h05; rom[1] = 8'h06; rom[10'h200] = 8'h07;
        do_reset("rst4");
        rst = 1'b0;
        step();
        check("co_first_valid", 32'(bus.instr_valid), 32'h1);
        push(24'h000005, 2'd1, 10'd0);
        bus.instr_ready = 1'b1;
        bus.br_en       = 1'b1;
        bus.br_addr     = 10'h200;
        step();
        bus.instr_ready = 1'b0;
        bus.br_en       = 1'b0;
        check("co_valid_low", 32'(bus.instr_valid), 32'h0);
        check("co_rom_addr",  32'(bus.rom_addr), 32'h200);
        check("co_sb_count",  32'(sb.size()), 32'h0);
        step();
        check("co_target_valid", 32'(bus.instr_valid), 32'h1);
        check("co_target_instr", 32'(bus.instr), 32'h07);
        push(24'h000007, 2'd1, 10'h200);
        accept_one();
        drain("co");

        // Reset in the middle of collection
        clear_rom();
        rom[0] = 8'hC1; rom[1] = 8'h22; rom[2] = 8'h33;
        do_reset("rst5");
        rst = 1'b0;
        step();
        check("mid_collect_rom_addr", 32'(bus.rom_addr), 32'h1);
        rst = 1'b1;
        step();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        step();
        step();
        step();
        check("mid_refetch_valid", 32'(bus.instr_valid), 32'h1);
        check("mid_refetch_instr", 32'(bus.instr), 32'h3322C1);
        drain("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
